// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, handler entry
// and the victim-PC to EPC rule.
package cp0_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HW_W   = 6;
  localparam int unsigned EXC_W  = 5;

  localparam logic [ADDR_W-1:0] CP0_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC   = 5'd14;

  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  localparam logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_4180;

  // A delay-slot victim restarts at its branch, one word earlier.
  function automatic logic [DATA_W-1:0] victim_epc(input logic [DATA_W-1:0] vpc,
                                                   input logic bd);
    logic [DATA_W-1:0] aligned;
    aligned = {vpc[DATA_W-1:2], 2'b00};
    return bd ? aligned - DATA_W'(4) : aligned;
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC, zero-latency exception and
// interrupt request, mfc0 read port, mtc0 writes and eret.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [HW_W-1:0]   im;
  logic              exl;
  logic              ie;
  logic              bd;
  logic [HW_W-1:0]   ip;
  logic [EXC_W-1:0]  exc_code;
  logic [DATA_W-1:0] epc;

  logic int_req;
  logic exc_req;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != EXC_INT) & ~exl;
  // Reset must drop the request without waiting for an edge.
  assign Req     = ~reset & (int_req | exc_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
        bd       <= BDIn;
        epc      <= victim_epc(VPC, BDIn);
      end else begin
        if (en && CP0Add == CP0_SR) begin
          im  <= CP0In[15:10];
          exl <= CP0In[1];
          ie  <= CP0In[0];
        end else if (en && CP0Add == CP0_EPC) begin
          epc <= {CP0In[31:2], 2'b00};
        end
        if (EXLClr) exl <= 1'b0;
      end
    end
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      CP0_SR:    CP0Out = {16'b0, im, 8'b0, exl, ie};
      CP0_CAUSE: CP0Out = {bd, 15'b0, ip, 3'b0, exc_code, 2'b00};
      CP0_EPC:   CP0Out = epc;
      default:   CP0Out = '0;
    endcase
  end

  assign EPCOut = epc;

  // Handler address is consumed by fetch; bits below are intentionally unread.
  logic unused_ok;
  assign unused_ok = ^{HANDLER_PC, CP0In[31:16], CP0In[9:2], VPC[1:0]};

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: word-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  CP0Add = 5'd0;
  logic [31:0] CP0In = '0;
  logic [31:0] VPC = '0;
  logic        BDIn = 1'b0;
  logic [4:0]  ExcCodeIn = '0;
  logic [5:0]  HWInt = '0;
  logic        EXLClr = 1'b0;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int errors = 0;
  int checks = 0;

  // Reference model: the three architectural registers as plain words.
  logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;

  always #5 clk = ~clk;

  cp0 dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_int();
    logic [31:0] im_bits;
    im_bits = (m_sr >> 10) & 32'h3F;
    return ((32'(HWInt) & im_bits) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    if (reset) return 1'b0;
    return model_int() || (ExcCodeIn != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic r, i;
    if (reset) begin
      m_sr = '0; m_cause = '0; m_epc = '0;
    end else begin
      r = model_req();
      i = model_int();
      if (r) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (BDIn ? 32'h8000_0000 : 32'h0) | (i ? 32'h0 : (32'(ExcCodeIn) << 2));
        m_epc   = (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);
      end else begin
        if (en && CP0Add == 5'd12)      m_sr  = CP0In & 32'h0000_FC03;
        else if (en && CP0Add == 5'd14) m_epc = CP0In & 32'hFFFF_FFFC;
        if (EXLClr) m_sr = m_sr & ~32'h2;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("req", 32'(Req), 32'(model_req()));
    check("epcout", EPCOut, m_epc);
    check("cp0out", CP0Out, model_read(CP0Add));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; EXLClr = 1'b0; ExcCodeIn = '0; HWInt = '0; BDIn = 1'b0; CP0In = '0;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    CP0Add = a;
    #1;
    check(name, CP0Out, exp);
  endtask

  initial begin
    @(posedge clk); #1;
    check("rst_req", 32'(Req), 32'h0);
    read_chk("rst_sr", 5'd12, 32'h0);
    read_chk("rst_cause", 5'd13, 32'h0);
    read_chk("rst_epc", 5'd14, 32'h0);
    reset = 1'b0;
    step();

    // Interrupt: enable IM[10] and IE, then raise HWInt[0].
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    step();
    en = 1'b0; HWInt = 6'b000001; VPC = 32'h0000_1000;
    #1 check("int_req", 32'(Req), 32'h1);
    step();
    HWInt = '0;
    read_chk("int_sr", 5'd12, 32'h0000_0403);
    read_chk("int_cause", 5'd13, 32'h0000_0400);
    check("int_epc", EPCOut, 32'h0000_1000);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;

    // Reserved instruction in a delay slot.
    ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h0000_3008;
    #1 check("ri_req", 32'(Req), 32'h1);
    step();
    idle();
    read_chk("ri_cause", 5'd13, 32'h8000_0028);
    check("ri_epc", EPCOut, 32'h0000_3004);

    // EXL masks everything; eret reopens the pending interrupt.
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_FC03;
    step();
    en = 1'b0; ExcCodeIn = 5'd12; HWInt = 6'h3F; VPC = 32'h0000_5000;
    #1 check("exl_mask_req", 32'(Req), 32'h0);
    step();
    check("exl_mask_epc", EPCOut, 32'h0000_3004);
    ExcCodeIn = '0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    #1 check("eret_int_req", 32'(Req), 32'h1);
    step();
    idle();
    check("eret_int_epc", EPCOut, 32'h0000_5000);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;

    // mtc0 to EPC loses against a same-cycle exception.
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_1234; ExcCodeIn = 5'd4; VPC = 32'h0000_6004;
    #1 check("adel_req", 32'(Req), 32'h1);
    step();
    idle();
    check("adel_epc", EPCOut, 32'h0000_6004);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    step();
    en = 1'b0;
    read_chk("cause_ro", 5'd13, 32'h0000_0010);
    read_chk("other_addr", 5'd7, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] pick;
      idle();
      HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      ExcCodeIn = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'h0;
      BDIn      = 1'($urandom);
      VPC       = $urandom;
      CP0In     = $urandom;
      pick      = 5'($urandom_range(0, 4));
      CP0Add    = (pick < 5'd3) ? 5'd12 + pick : 5'($urandom);
      if ($urandom_range(0, 3) == 0) en = 1'b1;
      else if ($urandom_range(0, 3) == 0) EXLClr = 1'b1;
      step();
    end

    // Asynchronous reset while a request is pending.
    idle();
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_FC01;
    step();
    en = 1'b0; ExcCodeIn = 5'd8; HWInt = 6'h3F; VPC = 32'h0000_7000;
    #1 check("pre_rst_req", 32'(Req), 32'h1);
    #1 reset = 1'b1;
    #1 check("async_rst_req", 32'(Req), 32'h0);
    check("async_rst_epc", EPCOut, 32'h0);
    read_chk("async_rst_sr", 5'd12, 32'h0);
    read_chk("async_rst_cause", 5'd13, 32'h0);
    idle();
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
